// File: rtl/hack_imem_arbiter.sv
// Instruction-memory arbiter: the UART host has priority over the Hack CPU fetch path.
// While the host owns the port the CPU is stalled and sees a held instruction; the fetch is replayed afterwards.
module hack_imem_arbiter #(
  parameter int unsigned AW          = 18,
  parameter int unsigned DW          = 16,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   cpu_pc,
  output logic [DW-1:0] cpu_instr,
  output logic          cpu_stall,
  input  logic [15:0]   host_address,
  input  logic          host_wvalid,
  input  logic [DW-1:0] host_wdata,
  output logic          host_wready,
  input  logic          host_rvalid,
  output logic          host_rready,
  output logic          host_rrvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   write_count
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] IdleLast = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StCpu, StHost, StReplay} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic [15:0]     wcount_q, wcount_d;
  logic            fetch_q, fetch_d;
  logic [DW-1:0]   instr_q, instr_d;
  logic            rrvalid_q;
  logic            host_req;
  logic            unused_addr0;

  // Host addresses are byte addresses; bit 0 never selects a word.
  assign unused_addr0 = host_address[0];

  always_comb begin
    host_req    = host_wvalid | host_rvalid;
    host_wready = host_wvalid;
    host_rready = host_rvalid & ~host_wvalid;

    state_d  = state_q;
    idle_d   = idle_q;
    wcount_d = wcount_q;

    case (state_q)
      StCpu: begin
        if (host_req) begin
          state_d = StHost;
          idle_d  = '0;
        end
      end
      StHost: begin
        if (host_req) begin
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          state_d = StReplay;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StReplay: begin
        if (host_req) begin
          state_d = StHost;
          idle_d  = '0;
        end else begin
          state_d = StCpu;
        end
      end
      default: state_d = StCpu;
    endcase

    // A fresh grab from CPU state restarts the count, including its own write.
    if (state_q == StCpu && host_req) begin
      wcount_d = {15'b0, host_wready};
    end else if (host_wready && wcount_q != 16'hFFFF) begin
      wcount_d = wcount_q + 16'd1;
    end

    mem_wdata = host_wdata;
    if (host_req) begin
      mem_address = AW'(host_address[15:1]);
      mem_write   = host_wready;
      mem_read    = host_rready;
    end else begin
      mem_address = AW'(cpu_pc);
      mem_write   = 1'b0;
      mem_read    = 1'b1;
    end

    // Idle HOST cycles also read cpu_pc, but only CPU/REPLAY reads feed the CPU.
    fetch_d   = ~host_req & (state_q != StHost);
    instr_d   = fetch_q ? mem_rdata : instr_q;
    cpu_instr = instr_d;
    cpu_stall = (state_q != StCpu) | host_req;

    host_rrvalid = rrvalid_q;
    host_rdata   = mem_rdata;
    write_count  = wcount_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCpu;
      idle_q    <= '0;
      wcount_q  <= '0;
      fetch_q   <= 1'b0;
      instr_q   <= '0;
      rrvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wcount_q  <= wcount_d;
      fetch_q   <= fetch_d;
      instr_q   <= instr_d;
      rrvalid_q <= host_rready;
    end
  end

endmodule

// File: tb/tb_hack_imem_arbiter.sv
// Bench for hack_imem_arbiter: table of grant vectors, directed corner sequences and random
// traffic, all checked against a timeline model of host ownership and a reference memory image.
module tb_hack_imem_arbiter;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_pc, cpu_instr;
  logic        cpu_stall;
  logic [15:0] host_address, host_wdata, host_rdata;
  logic        host_wvalid, host_wready, host_rvalid, host_rready, host_rrvalid;
  logic        mem_read, mem_write;
  logic [17:0] mem_address;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] write_count;

  always #5 clk = ~clk;

  hack_imem_arbiter #(.AW(18), .DW(16), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .host_address(host_address), .host_wvalid(host_wvalid), .host_wdata(host_wdata),
    .host_wready(host_wready), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .host_rrvalid(host_rrvalid), .host_rdata(host_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .write_count(write_count)
  );

  // Single-port RAM with 1-cycle read latency.
  logic [15:0] ram [65536];
  always @(posedge clk) begin
    if (mem_write) ram[mem_address[15:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= ram[mem_address[15:0]];
  end

  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] ref_mem [65536];
  int          t, last_req;
  bit          have_req, prev_owned, prev_rready;
  logic [15:0] prev_fetch_val, prev_read_val, hold, wc;

  // Samples of the most recent cycle
  logic [15:0] s_instr, s_wc, s_rdata;
  logic        s_stall, s_rrvalid, s_wready, s_rready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (model cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; last_req = 0; have_req = 0; prev_owned = 0; prev_rready = 0;
    prev_fetch_val = '0; prev_read_val = '0; hold = '0; wc = '0;
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic cycle(input logic wv, input logic rv, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] pc);
    bit hreq, in_session, owned;
    logic [15:0] exp_instr;
    logic [17:0] exp_addr;
    @(negedge clk);
    host_wvalid = wv; host_rvalid = rv; host_address = addr; host_wdata = wd; cpu_pc = pc;
    #1;
    s_instr = cpu_instr; s_wc = write_count; s_rdata = host_rdata; s_stall = cpu_stall;
    s_rrvalid = host_rrvalid; s_wready = host_wready; s_rready = host_rready;

    hreq = wv | rv;
    // Host keeps the port through last_req+H; last_req+H+1 is the replay cycle.
    in_session = have_req && (t - last_req <= H + 1);
    owned = !hreq && !(have_req && (t - last_req <= H));
    exp_instr = prev_owned ? prev_fetch_val : hold;
    exp_addr = hreq ? {3'b0, addr[15:1]} : {2'b0, pc};

    chk("stall", cpu_stall, hreq || in_session);
    chk("wready", host_wready, wv);
    chk("rready", host_rready, rv & ~wv);
    chk("mem_write", mem_write, wv);
    chk("mem_read", mem_read, hreq ? (rv & ~wv) : 1'b1);
    chk("mem_addr", mem_address, exp_addr);
    if (wv) chk("mem_wdata", mem_wdata, wd);
    chk("instr", cpu_instr, exp_instr);
    chk("rrvalid", host_rrvalid, prev_rready);
    if (prev_rready) chk("rdata", host_rdata, prev_read_val);
    chk("wcount", write_count, wc);

    if (prev_owned) hold = exp_instr;
    if (hreq && !in_session) wc = {15'b0, wv};
    else if (wv && wc != 16'hFFFF) wc = wc + 16'd1;
    prev_owned = owned;
    prev_fetch_val = ref_mem[pc];
    prev_rready = rv & ~wv;
    prev_read_val = ref_mem[addr[15:1]];
    if (wv) ref_mem[addr[15:1]] = wd;
    if (hreq) begin
      have_req = 1;
      last_req = t;
    end
    t++;
  endtask

  task automatic idle(input int n, input logic [15:0] pc);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, pc);
  endtask

  typedef struct {
    logic wv, rv;
    logic exp_wready, exp_rready, exp_stall, exp_mwrite, exp_mread;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_cnt, instr_changes;
    logic [15:0] instr_ref, pc_r;
    int p;

    vecs[0] = '{wv: 0, rv: 0, exp_wready: 0, exp_rready: 0, exp_stall: 0, exp_mwrite: 0, exp_mread: 1};
    vecs[1] = '{wv: 1, rv: 0, exp_wready: 1, exp_rready: 0, exp_stall: 1, exp_mwrite: 1, exp_mread: 0};
    vecs[2] = '{wv: 0, rv: 1, exp_wready: 0, exp_rready: 1, exp_stall: 1, exp_mwrite: 0, exp_mread: 1};
    vecs[3] = '{wv: 1, rv: 1, exp_wready: 1, exp_rready: 0, exp_stall: 1, exp_mwrite: 1, exp_mread: 0};

    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    rst_n = 1'b0; host_wvalid = 0; host_rvalid = 0; host_address = '0; host_wdata = '0;
    cpu_pc = '0;
    model_reset();

    // Reset state and combinational grants (state is pinned to CPU while in reset).
    @(negedge clk); @(negedge clk); #1;
    chk("reset_instr", cpu_instr, 16'h0);
    chk("reset_stall", cpu_stall, 1'b0);
    chk("reset_rrvalid", host_rrvalid, 1'b0);
    chk("reset_wcount", write_count, 16'h0);
    for (int i = 0; i < 4; i++) begin
      host_wvalid = vecs[i].wv; host_rvalid = vecs[i].rv; host_address = 16'h0040;
      #1;
      chk("tbl_wready", host_wready, vecs[i].exp_wready);
      chk("tbl_rready", host_rready, vecs[i].exp_rready);
      chk("tbl_stall", cpu_stall, vecs[i].exp_stall);
      chk("tbl_mem_write", mem_write, vecs[i].exp_mwrite);
      chk("tbl_mem_read", mem_read, vecs[i].exp_mread);
    end
    host_wvalid = 0; host_rvalid = 0; host_address = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain fetch: 1-cycle latency, no stall.
    cycle(0, 0, 0, 0, 16'd0);
    cycle(0, 0, 0, 0, 16'd1);
    chk("fetch0", s_instr, 16'h1000);
    cycle(0, 0, 0, 0, 16'd2);
    chk("fetch1", s_instr, 16'h1001);
    cycle(0, 0, 0, 0, 16'd3);
    chk("fetch2", s_instr, 16'h1002);

    // Write burst: stall window and held instruction.
    cycle(1, 0, 16'h0000, 16'hAAAA, 16'd3);
    instr_ref = s_instr;
    cycle(1, 0, 16'h0002, 16'hBBBB, 16'd3);
    cycle(1, 0, 16'h0004, 16'hCCCC, 16'd3);
    stall_cnt = 0; instr_changes = 0;
    for (int i = 0; i < H + 2; i++) begin
      idle(1, 16'd3);
      if (i == 0) chk("burst_wcount", s_wc, 16'd3);
      if (s_stall) begin
        stall_cnt++;
        if (s_instr !== instr_ref) instr_changes++;
      end
    end
    chk("burst_stall_len", stall_cnt, H + 1);
    chk("burst_instr_held", instr_changes, 0);
    chk("ram_w0", ram[0], 16'hAAAA);
    chk("ram_w1", ram[1], 16'hBBBB);
    chk("ram_w2", ram[2], 16'hCCCC);

    // Host read of byte 6 holding 0x1234.
    cycle(1, 0, 16'h0006, 16'h1234, 16'd3);
    idle(H + 2, 16'd3);
    cycle(0, 1, 16'h0006, 0, 16'd3);
    idle(1, 16'd3);
    chk("read_rrvalid", s_rrvalid, 1'b1);
    chk("read_rdata", s_rdata, 16'h1234);
    idle(1, 16'd3);
    chk("read_rrvalid_pulse", s_rrvalid, 1'b0);

    // Simultaneous write and read: write first, read retried.
    idle(H + 2, 16'd3);
    cycle(1, 1, 16'h0008, 16'h5555, 16'd3);
    chk("sim_wready", s_wready, 1'b1);
    chk("sim_rready", s_rready, 1'b0);
    cycle(0, 1, 16'h0008, 0, 16'd3);
    chk("sim_rready_retry", s_rready, 1'b1);
    idle(1, 16'd3);
    chk("sim_rdata", s_rdata, 16'h5555);

    // Re-grab in the REPLAY cycle keeps the write count.
    idle(H + 2, 16'd3);
    cycle(1, 0, 16'h000A, 16'h7777, 16'd3);
    idle(H, 16'd3);
    cycle(1, 0, 16'h000C, 16'h8888, 16'd3);
    chk("regrab_stall", s_stall, 1'b1);
    idle(1, 16'd3);
    chk("regrab_wcount", s_wc, 16'd2);
    chk("regrab_stall_after", s_stall, 1'b1);

    // Reset mid-HOST with a pending read return.
    idle(H + 2, 16'd3);
    for (int i = 0; i < 5; i++) cycle(1, 0, 16'h0020 + 16'(2 * i), 16'h9000 + 16'(i), 16'd3);
    cycle(0, 1, 16'h0020, 0, 16'd3);
    chk("pre_reset_wcount", s_wc, 16'd5);
    @(negedge clk);
    host_rvalid = 1; host_address = 16'h0020; rst_n = 1'b0;
    #1;
    chk("midrst_wcount", write_count, 16'h0);
    chk("midrst_rrvalid", host_rrvalid, 1'b0);
    chk("midrst_stall_req", cpu_stall, 1'b1);
    host_rvalid = 0;
    #1;
    chk("midrst_stall_idle", cpu_stall, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    // Random traffic in phases of differing host activity.
    pc_r = 16'd5;
    for (int ph = 0; ph < 15; ph++) begin
      p = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 30 : 70);
      for (int i = 0; i < 200; i++) begin
        logic wv, rv;
        if (!s_stall) pc_r = 16'($urandom_range(0, 63));
        wv = ($urandom_range(0, 99) < p);
        rv = ($urandom_range(0, 99) < p);
        cycle(wv, rv, 16'($urandom_range(0, 127)), 16'($urandom), pc_r);
      end
      idle($urandom_range(0, H + 3), pc_r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
